// File: rtl/ht_pkg.sv
// Shared definitions for the Hadamard stream controllers: lane count,
// lane index width and the core-sequencing FSM encoding.
package ht_pkg;

    localparam int HT_LANES = 8;
    localparam int HT_IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CAPTURE
    } ht_state_e;

    function automatic logic is_last_lane(input logic [HT_IDX_W-1:0] idx);
        return idx == HT_IDX_W'(HT_LANES - 1);
    endfunction

endpackage

// File: rtl/ht_out_serializer.sv
// Output block buffer: loads all lanes of a transform result at once and
// streams them out lane by lane over a valid/ready handshake.
module ht_out_serializer
    import ht_pkg::*;
#(
    parameter int YW = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [HT_LANES*YW-1:0]   load_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [YW-1:0]            m_data,
    output logic                     m_last,
    output logic                     empty
);

    logic [YW-1:0]         obuf_q [HT_LANES];
    logic [YW-1:0]         obuf_d [HT_LANES];
    logic [HT_IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic                  full_q, full_d;

    // load is only issued while empty, so it never collides with a handshake
    always_comb begin
        obuf_d   = obuf_q;
        rd_idx_d = rd_idx_q;
        full_d   = full_q;
        if (load) begin
            for (int i = 0; i < HT_LANES; i++) begin
                obuf_d[i] = load_data[YW*i +: YW];
            end
            full_d   = 1'b1;
            rd_idx_d = '0;
        end else if (full_q && m_ready) begin
            if (is_last_lane(rd_idx_q)) begin
                full_d   = 1'b0;
                rd_idx_d = '0;
            end else begin
                rd_idx_d = rd_idx_q + HT_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HT_LANES; i++) begin
                obuf_q[i] <= '0;
            end
            rd_idx_q <= '0;
            full_q   <= 1'b0;
        end else begin
            obuf_q   <= obuf_d;
            rd_idx_q <= rd_idx_d;
            full_q   <= full_d;
        end
    end

    assign m_valid = full_q;
    assign m_data  = obuf_q[rd_idx_q];
    assign m_last  = full_q && is_last_lane(rd_idx_q);
    assign empty   = !full_q;

endmodule

// File: rtl/ht8_stream_ctrl.sv
// Stream controller for an external 8-point Hadamard core: gathers 8 input
// samples, launches the core, captures its result and serialises it out.
module ht8_stream_ctrl
    import ht_pkg::*;
#(
    parameter int XW       = 8,
    parameter int YW       = 10,
    parameter int CORE_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [XW-1:0]          s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [YW-1:0]          m_data,
    output logic                   m_last,
    output logic                   core_start,
    output logic [HT_LANES*XW-1:0] core_x,
    input  logic [HT_LANES*YW-1:0] core_y,
    output logic                   busy
);

    localparam logic [3:0] WAIT_LAST = (CORE_LAT > 1) ? 4'(CORE_LAT - 2) : 4'd0;

    ht_state_e             state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [XW-1:0]         xbuf_q [HT_LANES];
    logic [XW-1:0]         xbuf_d [HT_LANES];
    logic [HT_IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic                  in_full_q, in_full_d;
    logic                  out_empty;
    logic                  launch;
    logic                  capture;
    logic                  accept;

    // ready is gated by rst so it drops the moment reset is asserted
    assign s_ready = !in_full_q && !rst;
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_full_q && out_empty) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = (CORE_LAT == 1) ? ST_CAPTURE : ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    wait_cnt_d = '0;
                    state_d    = ST_CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        launch  = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_LAUNCH:  launch  = 1'b1;
            ST_CAPTURE: capture = 1'b1;
            default: ;
        endcase
    end

    assign core_start = launch;

    // writes are blocked while full, so core_x holds from launch to capture
    always_comb begin
        xbuf_d    = xbuf_q;
        wr_idx_d  = wr_idx_q;
        in_full_d = in_full_q;
        if (capture) begin
            in_full_d = 1'b0;
            wr_idx_d  = '0;
        end else if (accept) begin
            xbuf_d[wr_idx_q] = s_data;
            wr_idx_d         = wr_idx_q + HT_IDX_W'(1);
            if (is_last_lane(wr_idx_q)) in_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HT_LANES; i++) begin
                xbuf_q[i] <= '0;
            end
            wr_idx_q  <= '0;
            in_full_q <= 1'b0;
        end else begin
            xbuf_q    <= xbuf_d;
            wr_idx_q  <= wr_idx_d;
            in_full_q <= in_full_d;
        end
    end

    for (genvar i = 0; i < HT_LANES; i++) begin : g_core_x
        assign core_x[XW*i +: XW] = xbuf_q[i];
    end

    ht_out_serializer #(
        .YW(YW)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .load_data (core_y),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .empty     (out_empty)
    );

    assign busy = in_full_q || (wr_idx_q != '0) || !out_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_ht8_stream_ctrl.sv
// Bench for ht8_stream_ctrl: three controllers (CORE_LAT 2, 1, 15), each
// wired to a behavioural Hadamard core, checked against a scoreboard.
module tb_ht8_stream_ctrl;

    localparam int XW = 8;
    localparam int YW = 10;
    localparam int N  = 3;
    localparam int LAT [N] = '{2, 1, 15};

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic                 s_valid    [N];
    logic                 s_ready    [N];
    logic signed [XW-1:0] s_data     [N];
    logic                 m_valid    [N];
    logic                 m_ready    [N];
    logic signed [YW-1:0] m_data     [N];
    logic                 m_last     [N];
    logic                 core_start [N];
    logic [8*XW-1:0]      core_x     [N];
    logic [8*YW-1:0]      core_y     [N];
    logic                 busy       [N];
    logic                 cv         [N];
    logic [8*XW-1:0]      xl_w       [N];

    logic signed [YW-1:0] exp_q [N][$];
    int   rd_ptr [N];
    int   n_out [N];
    int   n_start [N];
    int   start_cyc [N];
    int   last_out_cyc [N];
    int   mv_rise [N];
    logic hold [N];
    logic prev_mv [N];
    logic prev_last [N];
    logic signed [YW-1:0] prev_data [N];

    int n_chk = 0;
    int n_pass = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] expv);
        n_chk++;
        if (obs !== expv) $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        else n_pass++;
    endtask

    function automatic int had_lane(input int b [8], input int i);
        int acc = 0;
        for (int j = 0; j < 8; j++) begin
            if ($countones(i & j) % 2 == 1) acc -= b[j];
            else acc += b[j];
        end
        return acc;
    endfunction

    function automatic logic [8*YW-1:0] had(input logic [8*XW-1:0] x);
        int b [8];
        logic [8*YW-1:0] r;
        for (int j = 0; j < 8; j++) b[j] = int'($signed(x[XW*j +: XW]));
        for (int i = 0; i < 8; i++) r[YW*i +: YW] = YW'(had_lane(b, i));
        return r;
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_inst
        localparam int L = LAT[k];
        logic [15:0]     sr;
        logic [8*XW-1:0] xl;

        ht8_stream_ctrl #(.XW(XW), .YW(YW), .CORE_LAT(L)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .s_valid    (s_valid[k]),
            .s_ready    (s_ready[k]),
            .s_data     (s_data[k]),
            .m_valid    (m_valid[k]),
            .m_ready    (m_ready[k]),
            .m_data     (m_data[k]),
            .m_last     (m_last[k]),
            .core_start (core_start[k]),
            .core_x     (core_x[k]),
            .core_y     (core_y[k]),
            .busy       (busy[k])
        );

        // core model: result valid only in the cycle L after core_start
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                sr <= '0;
                xl <= '0;
            end else begin
                sr <= {sr[14:0], core_start[k]};
                if (core_start[k]) xl <= core_x[k];
            end
        end
        assign cv[k]     = sr[L-1];
        assign xl_w[k]   = xl;
        assign core_y[k] = sr[L-1] ? had(xl) : 'x;
    end

    // output monitor / scoreboard consumer
    initial begin
        for (int k = 0; k < N; k++) begin
            rd_ptr[k] = 0; n_out[k] = 0; n_start[k] = 0; start_cyc[k] = 0;
            last_out_cyc[k] = 0; mv_rise[k] = 0; hold[k] = 0; prev_mv[k] = 0;
            prev_last[k] = 0; prev_data[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (rst) begin
                    rd_ptr[k]  = exp_q[k].size();
                    hold[k]    = 1'b0;
                    prev_mv[k] = 1'b0;
                end else begin
                    if (core_start[k]) begin
                        n_start[k]++;
                        start_cyc[k] = cyc;
                    end
                    if (cv[k]) check($sformatf("core_x_stable%0d", k), core_x[k], xl_w[k]);
                    if (hold[k]) begin
                        check($sformatf("hold_data%0d", k), m_data[k], prev_data[k]);
                        check($sformatf("hold_last%0d", k), m_last[k], prev_last[k]);
                    end
                    if (m_valid[k] && !prev_mv[k]) mv_rise[k] = cyc;
                    if (m_valid[k] && m_ready[k]) begin
                        if (rd_ptr[k] < exp_q[k].size()) begin
                            check($sformatf("out%0d_%0d", k, n_out[k]), m_data[k], exp_q[k][rd_ptr[k]]);
                            rd_ptr[k]++;
                        end else begin
                            check($sformatf("spurious_out%0d", k), m_valid[k], 1'b0);
                        end
                        check($sformatf("m_last%0d_%0d", k, n_out[k]), m_last[k], (n_out[k] % 8 == 7));
                        n_out[k]++;
                        last_out_cyc[k] = cyc;
                    end
                    hold[k]      = m_valid[k] && !m_ready[k];
                    prev_data[k] = m_data[k];
                    prev_last[k] = m_last[k];
                    prev_mv[k]   = m_valid[k];
                end
            end
        end
    end

    task automatic send_block(input int k, input int b [8], output int first_hs);
        int t;
        first_hs = -1;
        for (int i = 0; i < 8; i++) exp_q[k].push_back(YW'(had_lane(b, i)));
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            s_valid[k] = 1'b1;
            s_data[k]  = XW'(b[i]);
            t = 0;
            forever begin
                @(negedge clk);
                if (s_ready[k]) break;
                if (++t > 300) begin
                    check("sready_tmo", s_ready[k], 1'b1);
                    break;
                end
                @(posedge clk); #1;
            end
            if (i == 0) first_hs = cyc;
            @(posedge clk); #1;
        end
        s_valid[k] = 1'b0;
    endtask

    task automatic wait_mvalid(input int k, input int budget);
        int t = 0;
        forever begin
            @(negedge clk);
            if (m_valid[k]) break;
            if (++t > budget) begin
                check("mvalid_tmo", m_valid[k], 1'b1);
                break;
            end
        end
        #1;
    endtask

    task automatic wait_nout(input int k, input int target, input int budget);
        int t = 0;
        forever begin
            @(posedge clk); #2;
            if (n_out[k] >= target) break;
            if (++t > budget) begin
                check("drain_tmo", n_out[k], target);
                break;
            end
        end
    endtask

    initial begin
        int blk_a [8] = '{3, 7, 2, 0, 1, 0, 6, 3};
        int blk_b [8] = '{2, 4, -1, 7, -2, 9, -7, 5};
        int blk_c [8] = '{-1, 0, -2, 0, 0, -2, -1, 4};
        int blk_r [8] = '{1, -2, 3, -4, 5, -6, 7, -8};
        int blk_f [8] = '{2, -2, 1, -1, -3, 0, 1, -1};
        int hs, hs8, t, base, d;

        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            s_valid[k] = 1'b0; s_data[k] = '0; m_ready[k] = 1'b0;
        end
        #2;
        for (int k = 0; k < N; k++) begin
            check("rst_s_ready", s_ready[k], 1'b0);
            check("rst_m_valid", m_valid[k], 1'b0);
            check("rst_busy", busy[k], 1'b0);
            check("rst_m_data", m_data[k], 0);
            check("rst_core_x", core_x[k], 0);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) check("sready_after_rst", s_ready[k], 1'b1);

        // block A, sink always ready
        m_ready[0] = 1'b1;
        send_block(0, blk_a, hs);
        wait_mvalid(0, 50);
        check("A_latency", mv_rise[0] - hs, 12);
        check("A_first", m_data[0], 22);
        wait_nout(0, 8, 50);
        check("A_starts", n_start[0], 1);

        // blocks B and C back to back with sink stalled
        m_ready[0] = 1'b0;
        send_block(0, blk_b, hs);
        send_block(0, blk_c, hs);
        @(negedge clk);
        check("full_sready", s_ready[0], 1'b0);
        check("busy_full", busy[0], 1'b1);
        repeat (20) @(posedge clk);
        #2;
        check("C_withheld", n_start[0], 2);
        check("B_hold_valid", m_valid[0], 1'b1);
        m_ready[0] = 1'b1;
        wait_nout(0, 16, 50);
        hs8 = last_out_cyc[0];
        t = 0;
        while (n_start[0] < 3 && t < 20) begin
            @(posedge clk); #2;
            t++;
        end
        d = start_cyc[0] - hs8;
        check("C_launch_after_drain", (n_start[0] == 3) && (d >= 1) && (d <= 2), 1'b1);
        wait_mvalid(0, 50);
        check("C_first", m_data[0], -2);
        wait_nout(0, 24, 50);

        // toggling sink ready during drain
        m_ready[0] = 1'b0;
        send_block(0, blk_r, hs);
        wait_mvalid(0, 50);
        for (int i = 0; i < 40 && n_out[0] < 32; i++) begin
            @(posedge clk); #1;
            m_ready[0] = (i % 2 == 0);
        end
        #2;
        check("R_count", n_out[0], 32);
        m_ready[0] = 1'b1;

        // reset while the core is in flight
        send_block(0, blk_a, hs);
        t = 0;
        forever begin
            @(negedge clk);
            if (core_start[0]) break;
            if (++t > 40) begin
                check("start_tmo", core_start[0], 1'b1);
                break;
            end
        end
        base = n_out[0];
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_s_ready", s_ready[0], 1'b0);
        check("midrst_m_valid", m_valid[0], 1'b0);
        check("midrst_m_last", m_last[0], 1'b0);
        check("midrst_core_start", core_start[0], 1'b0);
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_m_data", m_data[0], 0);
        check("midrst_core_x", core_x[0], 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("sready_after_midrst", s_ready[0], 1'b1);
        repeat (20) @(posedge clk);
        #2;
        check("no_out_after_rst", n_out[0], base);
        send_block(0, blk_f, hs);
        wait_mvalid(0, 50);
        check("F_first", m_data[0], -3);
        wait_nout(0, base + 8, 50);

        // extreme core latencies
        for (int k = 1; k < N; k++) begin
            m_ready[k] = 1'b1;
            send_block(k, blk_a, hs);
            wait_mvalid(k, 60);
            check($sformatf("lat%0d_latency", LAT[k]), mv_rise[k] - hs, 10 + LAT[k]);
            check($sformatf("lat%0d_first", LAT[k]), m_data[k], 22);
            wait_nout(k, 8, 60);
            check($sformatf("lat%0d_starts", LAT[k]), n_start[k], 1);
        end

        repeat (5) @(posedge clk);
        #2;
        for (int k = 0; k < N; k++) begin
            check($sformatf("sb_drained%0d", k), rd_ptr[k], exp_q[k].size());
            check($sformatf("idle_busy%0d", k), busy[k], 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
